// File: rtl/csa_accumulator.sv
// Packet accumulator keeping the running total in carry-save form, then resolving
// it with a CHUNK-wide carry-propagate adder over len/CHUNK cycles.
module csa_accumulator #(
   parameter int len   = 128,
   parameter int CHUNK = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [len-1:0]   din_i,
   input  logic             valid_i,
   input  logic             last_i,
   output logic             ready_o,
   output logic [len-1:0]   sum_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [1:0]       state_o
);

   localparam int N  = len / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   localparam logic [1:0] ST_ACC     = 2'd0;
   localparam logic [1:0] ST_RESOLVE = 2'd1;
   localparam logic [1:0] ST_OUT     = 2'd2;

   if ((CHUNK < 1) || (len < CHUNK) || ((len % CHUNK) != 0)) begin : g_bad_params
      $error("csa_accumulator: len must be a non-zero multiple of CHUNK");
   end

   // Handshakes: a beat moves on a rising edge with valid_i && ready_o; a result
   // moves on a rising edge with valid_o && ready_i. Neither side may retract.
   logic [1:0]     state_q, state_d;
   logic [len-1:0] ps_q, ps_d;
   logic [len-1:0] cy_q, cy_d;
   logic           c_q, c_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [len-1:0] sum_q, sum_d;

   logic [CHUNK:0] slice_sum;
   logic [len-1:0] resolved;
   logic [len-1:0] maj;

   assign slice_sum = {1'b0, ps_q[CHUNK-1:0]} + {1'b0, cy_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, c_q};
   // The resolved slice enters at the top of ps while ps/cy shift down, so after
   // N steps ps holds the full sum with slice 0 at the bottom.
   assign resolved  = (ps_q >> CHUNK) | (len'(slice_sum[CHUNK-1:0]) << (len - CHUNK));
   assign maj       = (ps_q & cy_q) | (ps_q & din_i) | (cy_q & din_i);

   always_comb begin
      state_d = state_q;
      ps_d    = ps_q;
      cy_d    = cy_q;
      c_d     = c_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      case (state_q)
         ST_ACC: begin
            if (valid_i) begin
               ps_d = ps_q ^ cy_q ^ din_i;
               cy_d = maj << 1;
               if (last_i) begin
                  state_d = ST_RESOLVE;
                  c_d     = 1'b0;
                  idx_d   = '0;
               end
            end
         end
         ST_RESOLVE: begin
            ps_d  = resolved;
            cy_d  = cy_q >> CHUNK;
            c_d   = slice_sum[CHUNK];
            idx_d = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = ST_OUT;
               sum_d   = resolved;
            end
         end
         ST_OUT: begin
            if (ready_i) begin
               state_d = ST_ACC;
               ps_d    = '0;
               cy_d    = '0;
               c_d     = 1'b0;
               idx_d   = '0;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACC;
         ps_q    <= '0;
         cy_q    <= '0;
         c_q     <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         cy_q    <= cy_d;
         c_q     <= c_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
      end
   end

   assign ready_o = (state_q == ST_ACC);
   assign valid_o = (state_q == ST_OUT);
   assign sum_o   = sum_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator at len=128, CHUNK=32: reset, accumulation,
// slice carries, wrap-around, ignored inputs, mid-packet reset and back-to-back packets.
module tb_csa_accumulator;

   localparam int LEN = 128;

   logic           clk = 1'b0;
   logic           rst;
   logic [LEN-1:0] din_i;
   logic           valid_i;
   logic           last_i;
   logic           ready_o;
   logic [LEN-1:0] sum_o;
   logic           valid_o;
   logic           ready_i;
   logic [1:0]     state_o;

   int vectors = 0;
   int errors  = 0;

   csa_accumulator #(.len(LEN), .CHUNK(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .din_i   (din_i),
      .valid_i (valid_i),
      .last_i  (last_i),
      .ready_o (ready_o),
      .sum_o   (sum_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .state_o (state_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [LEN-1:0] obs, input logic [LEN-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [LEN-1:0] d, input logic l);
      int n;
      n = 0;
      while (!ready_o && n < 50) begin
         step();
         n++;
      end
      if (!ready_o) check("ready_wait", {127'b0, ready_o}, 128'd1);
      valid_i = 1'b1;
      din_i   = d;
      last_i  = l;
      step();
      valid_i = 1'b0;
      last_i  = 1'b0;
      din_i   = '0;
   endtask

   // Counts edges from the last acceptance until valid_o rises.
   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (!valid_o && n < 20) begin
         step();
         n++;
      end
      check(tag, 128'(n), 128'd4);
   endtask

   task automatic handshake();
      check("ready_o_low_in_out", {127'b0, ready_o}, 128'd0);
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      check("ready_o_after_out", {127'b0, ready_o}, 128'd1);
      check("valid_o_after_out", {127'b0, valid_o}, 128'd0);
   endtask

   logic [LEN-1:0] all_ones;

   initial begin
      all_ones = '1;
      rst     = 1'b1;
      din_i   = '0;
      valid_i = 1'b0;
      last_i  = 1'b0;
      ready_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("reset_ready_o", {127'b0, ready_o}, 128'd1);
      check("reset_valid_o", {127'b0, valid_o}, 128'd0);
      check("reset_sum_o", sum_o, 128'd0);

      // 1 + 2 + 3, then hold the result with ready_i low
      send(128'd1, 1'b0);
      send(128'd2, 1'b0);
      send(128'd3, 1'b1);
      wait_out("latency_123");
      check("sum_123", sum_o, 128'd6);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_sum", sum_o, 128'd6);
         check("hold_valid", {127'b0, valid_o}, 128'd1);
      end
      handshake();

      // carry out of slice 0, then out of slice 2
      send(128'hFFFF_FFFF, 1'b0);
      send(128'd1, 1'b1);
      wait_out("latency_c32");
      check("sum_c32", sum_o, 128'h1_0000_0000);
      handshake();
      send((128'd1 << 96) - 128'd1, 1'b0);
      send(128'd1, 1'b1);
      wait_out("latency_c96");
      check("sum_c96", sum_o, 128'd1 << 96);
      handshake();

      // wrap modulo 2^128
      send(all_ones, 1'b0);
      send(128'd2, 1'b1);
      wait_out("latency_wrap");
      check("sum_wrap", sum_o, 128'd1);
      handshake();

      // valid_i held high with 0xAA through RESOLVE and OUT is ignored
      send(128'd3, 1'b0);
      send(128'd4, 1'b1);
      valid_i = 1'b1;
      din_i   = 128'hAA;
      last_i  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("ignore_ready_resolve", {127'b0, ready_o}, 128'd0);
         step();
      end
      step();
      check("ignore_valid_o", {127'b0, valid_o}, 128'd1);
      check("ignore_sum", sum_o, 128'd7);
      step();
      check("ignore_sum_out", sum_o, 128'd7);
      handshake();
      valid_i = 1'b0;
      last_i  = 1'b0;
      din_i   = '0;

      // reset during RESOLVE abandons {9, 9}
      send(128'd9, 1'b0);
      send(128'd9, 1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_ready", {127'b0, ready_o}, 128'd1);
      check("rst_mid_sum", sum_o, 128'd0);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 8; i++) begin
            step();
            if (valid_o) seen = 1'b1;
         end
         check("rst_no_output", {127'b0, seen}, 128'd0);
      end
      send(128'd5, 1'b0);
      send(128'd7, 1'b1);
      wait_out("latency_57");
      check("sum_57", sum_o, 128'd12);
      handshake();

      // back-to-back single-beat packets with ready_i held high
      ready_i = 1'b1;
      send(128'hDEAD_BEEF, 1'b1);
      wait_out("latency_b2b0");
      check("sum_b2b0", sum_o, 128'hDEAD_BEEF);
      check("b2b0_ready_low", {127'b0, ready_o}, 128'd0);
      step();
      check("b2b0_ready_after", {127'b0, ready_o}, 128'd1);
      send(128'h1234, 1'b1);
      wait_out("latency_b2b1");
      check("sum_b2b1", sum_o, 128'h1234);
      check("b2b1_ready_low", {127'b0, ready_o}, 128'd0);
      step();
      check("b2b1_done", {127'b0, valid_o}, 128'd0);
      ready_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
